bus_responder_alu: RTL and testbench

// Slave end of the SDSU bus: accepts valid/exec/write register writes from the bus master.

---
 rtl/sdsu_bus_pkg.sv | 20 ++
 rtl/seq_multiplier.sv | 54 +++++
 rtl/bus_responder_alu.sv | 157 +++++++++++++++
 tb/tb_bus_responder_alu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sdsu_bus_pkg.sv
// Shared definitions for the SDSU bus responder: register map, ALU opcodes and FSM state codes.
package sdsu_bus_pkg;

  localparam int unsigned ADDR_CTL = 0;
  localparam int unsigned ADDR_OPA = 1;
  localparam int unsigned ADDR_OPB = 2;
  localparam int unsigned ADDR_RES = 3;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_XOR = 2'd3
  } opcode_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per cycle, DATA_W cycles, low DATA_W product bits.
module seq_multiplier #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_last,
  output logic [DATA_W-1:0] o_product
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_p;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_p    <= '0;
      r_cnt  <= CNT_W'(DATA_W);
      r_busy <= 1'b1;
    end else if (r_busy) begin
      if (r_b[0]) begin
        r_p <= r_p + r_a;
      end
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNT_W'(1)) begin
        r_busy <= 1'b0;
      end
    end
  end

  // o_last marks the cycle whose edge applies the final partial product.
  assign o_busy    = r_busy;
  assign o_last    = r_busy && (r_cnt == CNT_W'(1));
  assign o_product = r_p;

endmodule

// File: rtl/bus_responder_alu.sv
// SDSU bus slave: operand/control register writes, register read-back, and an ALU job FSM.
module bus_responder_alu
  import sdsu_bus_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              exec,
  input  logic              write,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic [DATA_W-1:0] result_data,
  output logic              busy
);

  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_opa;
  logic [DATA_W-1:0] r_opb;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_result;
  opcode_e           r_opcode;
  logic              r_err;
  logic              r_ready;
  logic              r_busy;

  logic              w_xfer;
  logic              w_go;
  logic              w_sel_ctl;
  logic              w_sel_opa;
  logic              w_sel_opb;
  logic              w_wr_conflict;
  logic              w_mul_start;
  logic              w_mul_busy;
  logic              w_mul_last;
  logic [DATA_W-1:0] w_mul_product;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_rd_data;

  assign w_xfer    = valid & exec;
  assign w_go      = start | data[0];
  assign w_sel_ctl = (address == ADDR_W'(ADDR_CTL));
  assign w_sel_opa = (address == ADDR_W'(ADDR_OPA));
  assign w_sel_opb = (address == ADDR_W'(ADDR_OPB));

  // Operand writes and go commands outside IDLE (RUN or DONE) are dropped and flagged.
  assign w_wr_conflict = w_xfer && write && (r_state != ST_IDLE) &&
                         (w_sel_opa || w_sel_opb || (w_sel_ctl && w_go));

  assign w_mul_start = (r_state == ST_IDLE) && w_xfer && write && w_sel_ctl && w_go &&
                       (opcode_e'(data[2:1]) == OP_MUL);

  seq_multiplier #(
    .DATA_W (DATA_W)
  ) u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_mul_start),
    .i_a       (r_opa),
    .i_b       (r_opb),
    .o_busy    (w_mul_busy),
    .o_last    (w_mul_last),
    .o_product (w_mul_product)
  );

  always_comb begin
    w_alu = '0;
    case (r_opcode)
      OP_ADD:  w_alu = r_opa + r_opb;
      OP_SUB:  w_alu = r_opa - r_opb;
      OP_XOR:  w_alu = r_opa ^ r_opb;
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_rd_data = '0;
    if (w_sel_ctl) begin
      w_rd_data = DATA_W'({r_err, r_opcode, r_busy});
    end else if (w_sel_opa) begin
      w_rd_data = r_opa;
    end else if (w_sel_opb) begin
      w_rd_data = r_opb;
    end else if (address == ADDR_W'(ADDR_RES)) begin
      w_rd_data = r_result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_opcode <= OP_ADD;
      r_err    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (w_wr_conflict) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_xfer && write) begin
            if (w_sel_ctl) begin
              r_opcode <= opcode_e'(data[2:1]);
              if (w_go) begin
                r_state <= ST_RUN;
                r_busy  <= 1'b1;
              end
            end else if (w_sel_opa) begin
              r_opa <= data;
            end else if (w_sel_opb) begin
              r_opb <= data;
            end
          end else if (w_xfer) begin
            r_result <= w_rd_data;
            r_ready  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (r_opcode == OP_MUL) begin
            if (w_mul_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_acc   <= w_alu;
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          r_result <= (r_opcode == OP_MUL) ? w_mul_product : r_acc;
          r_ready  <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ready       = r_ready;
  assign result_data = r_result;
  assign busy        = r_busy;

endmodule

// File: tb/tb_bus_responder_alu.sv
// Directed-vector bench for bus_responder_alu with hand-computed expected values.
module tb_bus_responder_alu;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        exec;
  logic        write;
  logic        start;
  logic [31:0] address;
  logic [31:0] data;
  logic        ready;
  logic [31:0] result_data;
  logic        busy;

  int unsigned n_checks;
  int unsigned n_pass;

  bus_responder_alu #(
    .DATA_W (32),
    .ADDR_W (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .exec        (exec),
    .write       (write),
    .start       (start),
    .address     (address),
    .data        (data),
    .ready       (ready),
    .result_data (result_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic st);
    address = a;
    data    = d;
    start   = st;
    write   = 1'b1;
    valid   = 1'b1;
    exec    = 1'b1;
    tick();
    valid = 1'b0;
    exec  = 1'b0;
    start = 1'b0;
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a);
    address = a;
    write   = 1'b0;
    valid   = 1'b1;
    exec    = 1'b1;
    tick();
    valid = 1'b0;
    exec  = 1'b0;
  endtask

  // Called right after the go-write; counts edges to ready and cycles spent busy.
  task automatic wait_ready(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = busy ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      lat++;
      if (ready) break;
      if (busy) busy_cycles++;
    end
  endtask

  int lat;
  int bc;
  int pulses;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; valid = 1'b0; exec = 1'b0; write = 1'b0; start = 1'b0;
    address = '0; data = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_result", result_data, 32'd0);

    // add 7+5, cycle by cycle
    bus_write(32'd1, 32'd7, 1'b0);
    bus_write(32'd2, 32'd5, 1'b0);
    bus_write(32'd0, 32'b001, 1'b0);
    check("add_busy_run", {31'd0, busy}, 32'd1);
    check("add_ready_run", {31'd0, ready}, 32'd0);
    tick();
    check("add_busy_done", {31'd0, busy}, 32'd0);
    check("add_ready_done", {31'd0, ready}, 32'd0);
    tick();
    check("add_ready", {31'd0, ready}, 32'd1);
    check("add_result", result_data, 32'd12);
    tick();
    check("add_ready_pulse", {31'd0, ready}, 32'd0);
    check("add_result_hold", result_data, 32'd12);

    // sub with wrap
    bus_write(32'd1, 32'd3, 1'b0);
    bus_write(32'd2, 32'd5, 1'b0);
    bus_write(32'd0, 32'b011, 1'b0);
    wait_ready(lat, bc);
    check("sub_latency", lat, 32'd2);
    check("sub_result", result_data, 32'hFFFF_FFFE);

    // xor launched through the start flag with data[0]=0
    bus_write(32'd1, 32'h0000_F0F0, 1'b0);
    bus_write(32'd2, 32'h0000_FF00, 1'b0);
    bus_write(32'd0, 32'b110, 1'b1);
    wait_ready(lat, bc);
    check("xor_latency", lat, 32'd2);
    check("xor_result", result_data, 32'h0000_0FF0);

    // mul
    bus_write(32'd1, 32'h0001_0000, 1'b0);
    bus_write(32'd2, 32'h0001_0003, 1'b0);
    bus_write(32'd0, 32'b101, 1'b0);
    wait_ready(lat, bc);
    check("mul_latency", lat, 32'd33);
    check("mul_busy_cycles", bc, 32'd32);
    check("mul_result", result_data, 32'h0003_0000);

    // opcode-only control write: no job, opcode visible in CTL
    bus_write(32'd0, 32'b100, 1'b0);
    check("ctl_nogo_busy", {31'd0, busy}, 32'd0);
    bus_read(32'd0);
    check("ctl_nogo_read", result_data, 32'd4);

    // mul with a conflicting operand write and second go
    bus_write(32'd1, 32'd6, 1'b0);
    bus_write(32'd2, 32'd7, 1'b0);
    bus_write(32'd0, 32'b101, 1'b0);
    tick();
    tick();
    bus_write(32'd1, 32'd9, 1'b0);
    bus_write(32'd0, 32'b001, 1'b1);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      if (ready) break;
      tick();
      lat++;
    end
    check("mul2_ready_seen", {31'd0, ready}, 32'd1);
    check("mul2_result", result_data, 32'd42);
    tick();
    bus_read(32'd1);
    check("opa_unchanged", result_data, 32'd6);
    bus_read(32'd0);
    check("ctl_err", result_data, 32'd12);

    // read-back and unmapped accesses
    bus_write(32'd2, 32'h0000_ABCD, 1'b0);
    bus_read(32'd2);
    check("rd_opb_ready", {31'd0, ready}, 32'd1);
    check("rd_opb_data", result_data, 32'h0000_ABCD);
    bus_read(32'd7);
    check("rd_unmapped_ready", {31'd0, ready}, 32'd1);
    check("rd_unmapped_data", result_data, 32'd0);
    bus_read(32'd3);
    check("rd_res_data", result_data, 32'd0);
    bus_write(32'd3, 32'h1234_5678, 1'b0);
    check("wr_res_noready", {31'd0, ready}, 32'd0);
    bus_write(32'd7, 32'h1234_5678, 1'b1);
    check("wr_unmapped_busy", {31'd0, busy}, 32'd0);

    // reset in the middle of a mul job
    bus_write(32'd1, 32'd3, 1'b0);
    bus_write(32'd2, 32'd4, 1'b0);
    bus_read(32'd1);
    check("pre_rst_result", result_data, 32'd3);
    bus_write(32'd0, 32'b101, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_mid_ready", {31'd0, ready}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_result", result_data, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) pulses++;
    end
    check("rst_no_pulse", pulses, 32'd0);
    bus_read(32'd0);
    check("rst_ctl_clear", result_data, 32'd0);
    bus_read(32'd1);
    check("rst_opa_clear", result_data, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
